// File: rtl/instr_encoder_pkg.sv
// Shared opcode constants, state encoding and word-format helpers for instr_encoder.
package definitions;

  localparam logic [2:0] OP_SET  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;
  localparam logic [2:0] OP_RSVD = 3'b101;

  localparam logic [8:0] HALT_WORD = {OP_HALT, 6'b000000};

  typedef enum logic [2:0] {
    StIdle,
    StEmitSet,
    StEmitOp,
    StDone,
    StFull
  } enc_state_e;

  function automatic logic [8:0] set_word(input logic [1:0] mode);
    return {OP_SET, 4'b0000, mode};
  endfunction

endpackage

// File: rtl/instr_encoder.sv
// Streaming instruction encoder with decoder-mode shadow and sequential ROM addressing.
// Define SET_ELIDE_EN to suppress set prefixes when the shadowed mode already matches.
module instr_encoder
  import definitions::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [2:0]        ReqOp,
  input  logic [1:0]        ReqMode,
  input  logic [5:0]        ReqOperand,
  input  logic              ReqLabel,
  output logic              InstrValid,
  input  logic              InstrReady,
  output logic [8:0]        InstrOut,
  output logic [ADDR_W-1:0] InstrAddr,
  output logic              Done,
  output logic              Error
);

`ifdef SET_ELIDE_EN
  localparam bit ElideEn = 1'b1;
`else
  localparam bit ElideEn = 1'b0;
`endif

  enc_state_e        state_q;
  logic              instr_valid_q;
  logic [8:0]        instr_out_q;
  logic [ADDR_W-1:0] addr_q;
  logic              done_q;
  logic              error_q;
  logic [1:0]        shadow_mode_q;
  logic              shadow_valid_q;
  logic [2:0]        op_q;
  logic [5:0]        operand_q;
  logic [1:0]        mode_q;

  logic need_set;
  logic at_max;
  logic handshake;

  // A label invalidates the shadow before the comparison, so it forces a prefix.
  assign need_set  = !ElideEn || ReqLabel || !shadow_valid_q || (shadow_mode_q != ReqMode);
  assign at_max    = &addr_q;
  assign handshake = instr_valid_q && InstrReady;

  assign ReqReady   = (state_q == StIdle);
  assign InstrValid = instr_valid_q;
  assign InstrOut   = instr_out_q;
  assign InstrAddr  = addr_q;
  assign Done       = done_q;
  assign Error      = error_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q        <= StIdle;
      instr_valid_q  <= 1'b0;
      instr_out_q    <= '0;
      addr_q         <= '0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      shadow_mode_q  <= 2'b00;
      shadow_valid_q <= 1'b0;
      op_q           <= '0;
      operand_q      <= '0;
      mode_q         <= 2'b00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ReqValid) begin
            if (ReqLabel) shadow_valid_q <= 1'b0;
            op_q      <= ReqOp;
            operand_q <= ReqOperand;
            if (ReqOp == OP_RSVD) begin
              error_q <= 1'b1;
            end else if (ReqOp == OP_HALT) begin
              instr_out_q   <= HALT_WORD;
              instr_valid_q <= 1'b1;
              state_q       <= StEmitOp;
            end else if (ReqOp == OP_SET) begin
              mode_q        <= ReqOperand[1:0];
              instr_out_q   <= set_word(ReqOperand[1:0]);
              instr_valid_q <= 1'b1;
              state_q       <= StEmitOp;
            end else begin
              mode_q        <= ReqMode;
              instr_valid_q <= 1'b1;
              if (need_set) begin
                instr_out_q <= set_word(ReqMode);
                state_q     <= StEmitSet;
              end else begin
                instr_out_q <= {ReqOp, ReqOperand};
                state_q     <= StEmitOp;
              end
            end
          end
        end
        StEmitSet: begin
          if (handshake) begin
            shadow_mode_q  <= mode_q;
            shadow_valid_q <= 1'b1;
            if (at_max) begin
              instr_valid_q <= 1'b0;
              error_q       <= 1'b1;
              state_q       <= StFull;
            end else begin
              addr_q      <= addr_q + 1'b1;
              instr_out_q <= {op_q, operand_q};
              state_q     <= StEmitOp;
            end
          end
        end
        StEmitOp: begin
          if (handshake) begin
            instr_valid_q <= 1'b0;
            if (op_q == OP_SET) begin
              shadow_mode_q  <= mode_q;
              shadow_valid_q <= 1'b1;
            end
            if (!at_max) addr_q <= addr_q + 1'b1;
            if (op_q == OP_HALT) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else if (at_max) begin
              // Last address consumed: no further request can be placed.
              error_q <= 1'b1;
              state_q <= StFull;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StDone: state_q <= StDone;
        StFull: state_q <= StFull;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
